// File: rtl/m_mem_unit.sv
// Memory-stage access unit: decodes M-stage loads/stores, runs a req/ack
// transaction to data memory with timeout, and returns extended load data.
module m_mem_unit #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned SUBWORD_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m_valid,
  input  logic [31:0]       instr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_be,
  output logic [31:0]       dm_wdata,
  input  logic              dm_ack,
  input  logic [31:0]       dm_rdata,
  output logic              stall,
  output logic              ld_valid,
  output logic [31:0]       ld_data,
  output logic              exc_adel,
  output logic              exc_ades,
  output logic              bus_err
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit SUB = (SUBWORD_EN != 0);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  size_t            ld_size_q;
  logic             ld_uns_q;
  logic [1:0]       off_q;

  logic             op_ld;
  logic             op_st;
  size_t            op_size;
  logic             op_uns;
  logic             aligned;
  logic             go_c;
  logic [3:0]       st_be;
  logic [31:0]      st_wdata;
  logic             unused_instr_c;

  // Only the opcode field matters to this stage
  assign unused_instr_c = ^instr[25:0];

  // Opcode decode: memory-op class, access size and signedness
  always_comb begin
    op_ld   = 1'b0;
    op_st   = 1'b0;
    op_size = SZ_W;
    op_uns  = 1'b0;
    case (instr[31:26])
      6'b100011: op_ld = 1'b1;
      6'b101011: op_st = 1'b1;
      6'b100000: begin op_ld = SUB; op_size = SZ_B; end
      6'b100100: begin op_ld = SUB; op_size = SZ_B; op_uns = 1'b1; end
      6'b100001: begin op_ld = SUB; op_size = SZ_H; end
      6'b100101: begin op_ld = SUB; op_size = SZ_H; op_uns = 1'b1; end
      6'b101000: begin op_st = SUB; op_size = SZ_B; end
      6'b101001: begin op_st = SUB; op_size = SZ_H; end
      default: ;
    endcase
  end

  // Natural alignment check and store lane placement
  always_comb begin
    aligned  = 1'b1;
    st_be    = 4'b1111;
    st_wdata = wdata;
    case (op_size)
      SZ_W: aligned = (addr[1:0] == 2'b00);
      SZ_H: aligned = ~addr[0];
      default: aligned = 1'b1;
    endcase
    if (op_st) begin
      case (op_size)
        SZ_B: begin
          st_be    = 4'(4'b0001 << addr[1:0]);
          st_wdata = {4{wdata[7:0]}};
        end
        SZ_H: begin
          st_be    = addr[1] ? 4'b1100 : 4'b0011;
          st_wdata = {2{wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  assign go_c     = (state == S_IDLE) & m_valid & (op_ld | op_st) & aligned;
  assign stall    = reset & (go_c | (state == S_BUSY));
  assign exc_adel = reset & (state == S_IDLE) & m_valid & op_ld & ~aligned;
  assign exc_ades = reset & (state == S_IDLE) & m_valid & op_st & ~aligned;

  // Select the addressed lane of a load word and extend it to 32 bits
  function automatic logic [31:0] extend_load(input logic [31:0] d, input size_t sz,
                                              input logic uns, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{off, 3'b000} +: 8];
    h = off[1] ? d[31:16] : d[15:0];
    case (sz)
      SZ_B:    return uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_H:    return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return d;
    endcase
  endfunction

  // Access sequencer: capture in IDLE, wait for ack or timeout in BUSY, report in DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      dm_req    <= 1'b0;
      dm_we     <= 1'b0;
      dm_addr   <= '0;
      dm_be     <= 4'b0000;
      dm_wdata  <= 32'h0;
      ld_valid  <= 1'b0;
      ld_data   <= 32'h0;
      bus_err   <= 1'b0;
      ld_size_q <= SZ_W;
      ld_uns_q  <= 1'b0;
      off_q     <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          ld_valid <= 1'b0;
          bus_err  <= 1'b0;
          if (go_c) begin
            dm_req    <= 1'b1;
            dm_we     <= op_st;
            dm_addr   <= {addr[ADDR_W-1:2], 2'b00};
            dm_be     <= st_be;
            dm_wdata  <= st_wdata;
            ld_size_q <= op_size;
            ld_uns_q  <= op_uns;
            off_q     <= addr[1:0];
            wait_cnt  <= '0;
            state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (dm_ack) begin
            dm_req   <= 1'b0;
            ld_valid <= ~dm_we;
            if (!dm_we) ld_data <= extend_load(dm_rdata, ld_size_q, ld_uns_q, off_q);
            state    <= S_DONE;
          end else if (wait_cnt == CNT_LAST) begin
            dm_req   <= 1'b0;
            bus_err  <= 1'b1;
            ld_data  <= 32'h0;
            state    <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          ld_valid <= 1'b0;
          bus_err  <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m_mem_unit.sv
// Self-checking bench for m_mem_unit: directed plan cases plus randomized
// back-to-back traffic against a transaction-level reference model.
module tb_m_mem_unit;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned TIMEOUT = 16;

  localparam logic [5:0] OP_LW = 6'b100011, OP_LB = 6'b100000, OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH = 6'b100001, OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SW = 6'b101011, OP_SB = 6'b101000, OP_SH = 6'b101001;

  logic              clk = 1'b0;
  logic              reset;
  logic              m_valid;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [3:0]        dm_be;
  logic [31:0]       dm_wdata;
  logic              dm_ack;
  logic [31:0]       dm_rdata;
  logic              stall;
  logic              ld_valid;
  logic [31:0]       ld_data;
  logic              exc_adel;
  logic              exc_ades;
  logic              bus_err;

  int n_cmp = 0;
  int n_err = 0;

  m_mem_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .SUBWORD_EN(1)) dut (
    .clk(clk), .reset(reset), .m_valid(m_valid), .instr(instr), .addr(addr),
    .wdata(wdata), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .stall(stall), .ld_valid(ld_valid), .ld_data(ld_data),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (transaction level) ----------------
  function automatic int op_size(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW:          return 4;
      OP_LH, OP_LHU, OP_SH:  return 2;
      OP_LB, OP_LBU, OP_SB:  return 1;
      default:               return 0;
    endcase
  endfunction

  function automatic bit op_is_load(input logic [5:0] op);
    return (op_size(op) != 0) && (op[5:3] == 3'b100);
  endfunction

  function automatic bit op_is_store(input logic [5:0] op);
    return (op_size(op) != 0) && (op[5:3] == 3'b101);
  endfunction

  function automatic bit op_aligned(input logic [5:0] op, input logic [31:0] a);
    int sz;
    sz = op_size(op);
    if (sz == 0) return 1'b1;
    return (int'(a[1:0]) % sz) == 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [5:0] op, input logic [31:0] a);
    int sz;
    int off;
    sz  = op_size(op);
    off = int'(a[1:0]);
    if (op_is_load(op) || sz == 4) return 4'hF;
    if (sz == 1) return 4'(1 << off);
    return (off >= 2) ? 4'hC : 4'h3;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [5:0] op, input logic [31:0] wd);
    int sz;
    sz = op_size(op);
    if (sz == 1) return 32'(wd & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return 32'(wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] a,
                                             input logic [31:0] rd);
    int sz;
    int off;
    logic [31:0] v;
    sz  = op_size(op);
    off = int'(a[1:0]);
    if (sz == 4) return rd;
    if (sz == 1) v = (rd >> (8 * off)) & 32'hFF;
    else         v = (rd >> ((off >= 2) ? 16 : 0)) & 32'hFFFF;
    if ((op == OP_LB || op == OP_LH) && v >= (32'h1 << (8 * sz - 1)))
      v = v - (32'h1 << (8 * sz));
    return v;
  endfunction

  // ---------------- generic transaction runner ----------------
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int waits, input bit never_ack,
                        input string tag);
    bit          is_ld, is_st, al, mem, done, bus_bad, extra_req;
    int          stall_cnt, req_cnt, lv_cnt, be_cnt, exp_req, exp_stall;
    logic [31:0] done_ld, exp_ld;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    is_ld  = op_is_load(op);
    is_st  = op_is_store(op);
    mem    = is_ld | is_st;
    al     = op_aligned(op, a);
    exp_be = model_be(op, a);
    exp_wd = model_wdata(op, wd);
    exp_ld = model_load(op, a, rd);

    // IDLE issue cycle; a stray ack here must be ignored
    @(negedge clk);
    m_valid  = 1'b1;
    instr    = {op, 26'($urandom)};
    addr     = a;
    wdata    = wd;
    dm_ack   = 1'($urandom);
    dm_rdata = $urandom;
    #1;
    n_cmp++;
    if (stall !== (mem && al)) begin
      n_err++; $display("FAIL %s issue_stall: got %b want %b", tag, stall, mem && al);
    end
    n_cmp++;
    if (exc_adel !== (is_ld && !al)) begin
      n_err++; $display("FAIL %s exc_adel: got %b want %b", tag, exc_adel, is_ld && !al);
    end
    n_cmp++;
    if (exc_ades !== (is_st && !al)) begin
      n_err++; $display("FAIL %s exc_ades: got %b want %b", tag, exc_ades, is_st && !al);
    end

    if (!(mem && al)) begin
      extra_req = 1'b0;
      repeat (3) begin
        @(negedge clk);
        m_valid = 1'b0; dm_ack = 1'b0;
        #1;
        if (dm_req !== 1'b0 || stall !== 1'b0 || exc_adel !== 1'b0 || exc_ades !== 1'b0)
          extra_req = 1'b1;
      end
      n_cmp++;
      if (extra_req) begin
        n_err++; $display("FAIL %s no_access: got activity, want dm_req/stall/exc low", tag);
      end
      return;
    end

    stall_cnt = 1; req_cnt = 0; lv_cnt = 0; be_cnt = 0;
    done = 1'b0; bus_bad = 1'b0; done_ld = 32'h0;
    for (int cyc = 0; cyc < int'(TIMEOUT) + 8 && !done; cyc++) begin
      @(negedge clk);
      m_valid = 1'b0;
      instr   = $urandom;
      addr    = $urandom;
      wdata   = $urandom;
      if (dm_req && !never_ack && req_cnt == waits) begin
        dm_ack = 1'b1; dm_rdata = rd;
      end else begin
        dm_ack = dm_req ? 1'b0 : 1'($urandom); dm_rdata = $urandom;
      end
      #1;
      if (stall)    stall_cnt++;
      if (ld_valid) lv_cnt++;
      if (bus_err)  be_cnt++;
      if (dm_req) begin
        req_cnt++;
        if (dm_we !== is_st || dm_be !== exp_be || dm_addr !== (a & ~32'h3) ||
            (is_st && dm_wdata !== exp_wd)) begin
          if (!bus_bad)
            $display("FAIL %s bus: got we=%b be=%b addr=%h wd=%h want we=%b be=%b addr=%h wd=%h",
                     tag, dm_we, dm_be, dm_addr, dm_wdata, is_st, exp_be, a & ~32'h3, exp_wd);
          bus_bad = 1'b1;
        end
      end else begin
        done    = 1'b1;
        done_ld = ld_data;
      end
    end
    // One cycle past DONE: pulses must have ended
    @(negedge clk);
    m_valid = 1'b0; dm_ack = 1'b0;
    #1;
    if (stall)    stall_cnt++;
    if (ld_valid) lv_cnt++;
    if (bus_err)  be_cnt++;

    exp_req   = never_ack ? int'(TIMEOUT) : waits + 1;
    exp_stall = exp_req + 1;
    n_cmp++;
    if (!done) begin
      n_err++; $display("FAIL %s completion: got no DONE within budget, want DONE", tag);
    end
    n_cmp++;
    if (bus_bad) n_err++;
    n_cmp++;
    if (req_cnt != exp_req) begin
      n_err++; $display("FAIL %s req_cycles: got %0d want %0d", tag, req_cnt, exp_req);
    end
    n_cmp++;
    if (stall_cnt != exp_stall) begin
      n_err++; $display("FAIL %s stall_cycles: got %0d want %0d", tag, stall_cnt, exp_stall);
    end
    n_cmp++;
    if (lv_cnt != ((is_ld && !never_ack) ? 1 : 0)) begin
      n_err++; $display("FAIL %s ld_valid_pulses: got %0d want %0d", tag, lv_cnt,
                        (is_ld && !never_ack) ? 1 : 0);
    end
    n_cmp++;
    if (be_cnt != (never_ack ? 1 : 0)) begin
      n_err++; $display("FAIL %s bus_err_pulses: got %0d want %0d", tag, be_cnt,
                        never_ack ? 1 : 0);
    end
    if (never_ack) begin
      n_cmp++;
      if (done_ld !== 32'h0) begin
        n_err++; $display("FAIL %s abort_ld_data: got %h want 00000000", tag, done_ld);
      end
    end else if (is_ld) begin
      n_cmp++;
      if (done_ld !== exp_ld) begin
        n_err++; $display("FAIL %s ld_data: got %h want %h", tag, done_ld, exp_ld);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    reset    = 1'b0;
    m_valid  = 1'b1;
    instr    = {OP_LW, 26'h0};
    addr     = 32'h0;
    wdata    = 32'h0;
    dm_ack   = 1'b0;
    dm_rdata = 32'h0;
    #3;
    n_cmp++;
    if ({dm_req, dm_we, dm_addr, dm_be, dm_wdata, ld_valid, ld_data, bus_err, stall} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got req=%b we=%b addr=%h be=%b wd=%h lv=%b ld=%h be=%b st=%b want all 0",
               dm_req, dm_we, dm_addr, dm_be, dm_wdata, ld_valid, ld_data, bus_err, stall);
    end
    addr = 32'h6;
    #1;
    n_cmp++;
    if (exc_adel !== 1'b0 || stall !== 1'b0) begin
      n_err++; $display("FAIL reset_exc: got adel=%b stall=%b want 0 0", exc_adel, stall);
    end
    @(negedge clk);
    reset   = 1'b1;
    m_valid = 1'b0;
  endtask

  task automatic test_directed;
    run_op(OP_SW,  32'h0000_0010, 32'hDEAD_BEEF, 32'h0,          0, 1'b0, "sw_0x10");
    run_op(OP_LB,  32'h0000_0013, 32'h0,         32'h80FF_7F01,  2, 1'b0, "lb_0x13");
    run_op(OP_LBU, 32'h0000_0013, 32'h0,         32'h80FF_7F01,  2, 1'b0, "lbu_0x13");
    run_op(OP_LH,  32'h0000_0016, 32'h0,         32'h8001_1234,  0, 1'b0, "lh_0x16");
    run_op(OP_SH,  32'h0000_0016, 32'h0000_ABCD, 32'h0,          1, 1'b0, "sh_0x16");
    run_op(OP_LW,  32'h0000_0006, 32'h0,         32'h0,          0, 1'b0, "lw_misaligned");
    run_op(OP_SH,  32'h0000_0005, 32'h1234_5678, 32'h0,          0, 1'b0, "sh_misaligned");
  endtask

  task automatic test_timeout;
    run_op(OP_LW, 32'h0000_0040, 32'h0, 32'h1111_2222, 0, 1'b1, "lw_timeout");
    run_op(OP_SB, 32'h0000_0041, 32'h0000_005A, 32'h0, 0, 1'b0, "sb_after_timeout");
  endtask

  task automatic test_reset_mid_access;
    @(negedge clk);
    m_valid = 1'b1; instr = {OP_LW, 26'($urandom)}; addr = 32'h20; dm_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      m_valid = 1'b0; dm_ack = 1'b0;
    end
    #1;
    n_cmp++;
    if (dm_req !== 1'b1) begin
      n_err++; $display("FAIL mid_reset_pre_req: got %b want 1", dm_req);
    end
    #1;
    reset   = 1'b0;
    m_valid = 1'b1;
    instr   = {OP_LW, 26'h0};
    addr    = 32'h0;
    #1;
    n_cmp++;
    if (dm_req !== 1'b0 || stall !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_async: got req=%b stall=%b want 0 0", dm_req, stall);
    end
    n_cmp++;
    if (dm_addr !== '0 || dm_be !== 4'h0 || ld_valid !== 1'b0 || bus_err !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_regs: got addr=%h be=%b lv=%b be=%b want 0", dm_addr,
                        dm_be, ld_valid, bus_err);
    end
    @(negedge clk);
    reset   = 1'b1;
    m_valid = 1'b0;
    run_op(OP_SW, 32'h0000_0024, 32'hCAFE_F00D, 32'h0, 0, 1'b0, "sw_after_reset");
  endtask

  task automatic test_back_to_back_random;
    logic [5:0] ops [10];
    logic [5:0] op;
    ops = '{OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_SW, OP_SB, OP_SH, 6'b001000, 6'b100010};
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 9)];
      run_op(op, $urandom, $urandom, $urandom, int'($urandom_range(0, 3)),
             ($urandom_range(0, 9) == 0), $sformatf("rand%0d_op%b", i, op));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by 500000, want bench done");
    $fatal(1, "watchdog expired");
  end

endmodule
